ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter N_CL, default 4: number of RAM clients (coder, ntt, A_gen, CBD).
REQ-002 SHALL have parameter ADDR_W, default 8: RAM address width.
REQ-003 SHALL have parameter DATA_W, default 96: RAM word width.
REQ-004 SHALL have parameter RD_LAT, default 1: RAM read latency in cycles (1..4).
REQ-005 SHALL have port clk, input, 1: single clock; all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port rr_mode, input, 1: 0 = fixed priority (index 0 highest); 1 = round-robin.
REQ-008 SHALL have port req, input, N_CL: per-client ownership request; held high for the whole access burst.
REQ-009 SHALL have port gnt, output, N_CL: one-hot or zero; current owner.
REQ-010 SHALL have port cl_ren / cl_wen, input, N_CL each: per-client read and write strobes.
REQ-011 SHALL have port cl_raddr / cl_waddr, input, N_CL*ADDR_W each: flattened; client i occupies slice [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port cl_wdata, input, N_CL*DATA_W: flattened, same slicing rule.
REQ-013 SHALL have port ram_wen, ram_raddr, ram_waddr, ram_din, output, 1/ADDR_W/ADDR_W/DATA_W: RAM side.
REQ-014 SHALL have port ram_dout, input, DATA_W: RAM read data.
REQ-015 SHALL have port rdata, output, DATA_W: ram_dout broadcast to all clients.
REQ-016 SHALL have port rvalid, output, N_CL: one-hot; marks rdata valid for the issuing client.
REQ-017 SHALL have port viol, output, 1: sticky flag; set by any strobe from a non-owner.
REQ-018 SHALL have port busy, output, 1: high when the FSM is not in IDLE.

Function
REQ-019 SHALL implement the FSM IDLE -> OWN -> DRAIN -> IDLE.
REQ-020 In IDLE with any req high, SHALL select a winner and enter OWN with gnt set on the next edge (grant latency 1 cycle).
REQ-021 Winner selection: fixed mode takes the lowest set index; round-robin takes the first set index strictly after the last owner, wrapping at N_CL-1 -> 0.
REQ-022 In OWN, SHALL hold gnt while req[owner] is high; other requests SHALL NOT preempt.
REQ-023 In OWN, ram_* SHALL combinationally mirror the owner's strobes and slices; non-owner inputs SHALL be ignored.
REQ-024 When req[owner] falls, SHALL clear gnt on the next edge and enter DRAIN for RD_LAT cycles, then IDLE.
REQ-025 In IDLE and DRAIN, ram_wen SHALL be 0 and ram_raddr/ram_waddr/ram_din SHALL be 0.
REQ-026 Read tagging: a shift pipe of depth RD_LAT SHALL carry the one-hot owner tag for each granted cl_ren, so that rvalid[i] asserts exactly RD_LAT cycles after the issuing cycle.
REQ-027 Reads issued in OWN SHALL complete to the issuing client during DRAIN, even after gnt has dropped.
REQ-028 Any cl_wen[i] or cl_ren[i] with gnt[i]=0 SHALL be dropped and SHALL set viol; viol clears only on reset.
REQ-029 req rising in the same cycle the owner releases SHALL be served after DRAIN; no request SHALL be lost while it stays asserted.
REQ-030 Changing rr_mode SHALL take effect at the next IDLE arbitration only.
REQ-031 With req all-zero, the FSM SHALL stay in IDLE indefinitely.

Reset
REQ-032 With rst=0 at a clock edge: state=IDLE, gnt=0, rvalid=0, tag pipe cleared, viol=0, busy=0, last-owner pointer=N_CL-1 (so the first round-robin pick is index 0).
REQ-033 Reset mid-burst SHALL abort immediately: no rvalid SHALL appear after reset is released for reads issued before it.
REQ-034 ram_wen SHALL be 0 during any cycle in which rst=0.

Structure
REQ-035 Shared package kyber_ram_pkg SHALL hold KY_ADDR_W=8, KY_DATA_W=96, and client index constants CL_CODER=0, CL_NTT=1, CL_AGEN=2, CL_CBD=3.
REQ-036 Round-robin selection SHALL be a sub-module rr_pick: inputs req and last-owner index, output one-hot winner; purely combinational.
REQ-037 Target implementation size is 150-300 lines.

Verification
REQ-038 Fixed mode, req=4'b1010 from IDLE -> gnt=4'b0010 after 1 cycle; holds while req[1]=1.
REQ-039 Round-robin, req=4'b1111 held, each owner releasing after 3 writes -> grant order 0,1,2,3,0; DRAIN of RD_LAT cycles between each grant.
REQ-040 RD_LAT=2, owner 2 reads addr 8'h10 then releases req the same cycle -> rvalid=4'b0100 two cycles later, with rdata equal to RAM[8'h10].
REQ-041 Client 3 asserts cl_wen while client 0 owns -> RAM unchanged at client 3's address; viol=1 and remains 1 until reset.
REQ-042 Reset asserted one cycle after a read is issued -> rvalid=0 throughout, gnt=0, state IDLE after release.

Source files
------------

// File: rtl/kyber_ram_pkg.sv
// Shared constants and types for the Kyber RAM port arbiter.
package kyber_ram_pkg;

  localparam int unsigned KY_ADDR_W = 8;
  localparam int unsigned KY_DATA_W = 96;

  // Client slots on the shared RAM port.
  localparam int unsigned CL_CODER = 0;
  localparam int unsigned CL_NTT   = 1;
  localparam int unsigned CL_AGEN  = 2;
  localparam int unsigned CL_CBD   = 3;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StDrain
  } arb_state_e;

  // Width of a client index; at least one bit even for a single client.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner pick: first requester strictly after the last owner, wrapping.
module rr_pick
  import kyber_ram_pkg::*;
#(
  parameter  int unsigned N_CL = 4,
  localparam int unsigned IdxW = idx_w(N_CL)
) (
  input  logic [N_CL-1:0] req_i,
  input  logic [IdxW-1:0] last_i,
  output logic [N_CL-1:0] win_o
);

  logic            found;
  int unsigned     pos;
  logic [IdxW-1:0] pos_idx;

  // Scan offsets 1..N_CL from the last owner; the last owner itself is checked last.
  always_comb begin
    win_o   = '0;
    found   = 1'b0;
    pos     = '0;
    pos_idx = '0;
    for (int unsigned k = 1; k <= N_CL; k++) begin
      pos     = (32'(last_i) + k) % N_CL;
      pos_idx = pos[IdxW-1:0];
      if (!found && req_i[pos_idx]) begin
        win_o[pos_idx] = 1'b1;
        found          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Single-port RAM ownership arbiter: burst grants, read-tag pipe, drain before re-arbitration.
module ram_port_arbiter
  import kyber_ram_pkg::*;
#(
  parameter int unsigned N_CL   = 4,
  parameter int unsigned ADDR_W = KY_ADDR_W,
  parameter int unsigned DATA_W = KY_DATA_W,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rr_mode,
  input  logic [N_CL-1:0]          req,
  output logic [N_CL-1:0]          gnt,
  input  logic [N_CL-1:0]          cl_ren,
  input  logic [N_CL-1:0]          cl_wen,
  input  logic [N_CL*ADDR_W-1:0]   cl_raddr,
  input  logic [N_CL*ADDR_W-1:0]   cl_waddr,
  input  logic [N_CL*DATA_W-1:0]   cl_wdata,
  output logic                     ram_wen,
  output logic [ADDR_W-1:0]        ram_raddr,
  output logic [ADDR_W-1:0]        ram_waddr,
  output logic [DATA_W-1:0]        ram_din,
  input  logic [DATA_W-1:0]        ram_dout,
  output logic [DATA_W-1:0]        rdata,
  output logic [N_CL-1:0]          rvalid,
  output logic                     viol,
  output logic                     busy
);

  localparam int unsigned IdxW = idx_w(N_CL);
  localparam int unsigned CntW = 3;

  arb_state_e      state_q;
  logic [N_CL-1:0] gnt_q;
  logic [IdxW-1:0] last_q;
  logic [CntW-1:0] drain_q;
  logic [N_CL-1:0] tag_q [RD_LAT];
  logic            viol_q;

  logic [N_CL-1:0] rr_win;
  logic [N_CL-1:0] fixed_win;
  logic            fixed_found;
  logic [N_CL-1:0] win;
  logic [IdxW-1:0] win_idx;
  logic            own;
  logic            owner_req;
  logic            own_ren;
  logic            own_wen;
  logic            stray;

  rr_pick #(
    .N_CL(N_CL)
  ) u_rr_pick (
    .req_i (req),
    .last_i(last_q),
    .win_o (rr_win)
  );

  // Fixed priority: lowest requesting index wins.
  always_comb begin
    fixed_win   = '0;
    fixed_found = 1'b0;
    for (int i = 0; i < N_CL; i++) begin
      if (!fixed_found && req[i]) begin
        fixed_win[i] = 1'b1;
        fixed_found  = 1'b1;
      end
    end
  end

  // Mode select and one-hot to index for the last-owner pointer.
  always_comb begin
    win     = rr_mode ? rr_win : fixed_win;
    win_idx = '0;
    for (int i = 0; i < N_CL; i++) begin
      if (win[i]) win_idx = IdxW'(i);
    end
  end

  assign own       = (state_q == StOwn);
  assign owner_req = |(req & gnt_q);
  assign own_ren   = own & |(cl_ren & gnt_q);
  assign own_wen   = own & |(cl_wen & gnt_q);
  // gnt_q is zero outside OWN, so any strobe there counts as stray.
  assign stray     = |((cl_ren | cl_wen) & ~gnt_q);

  // Mirror the owner's slices onto the RAM port; zeros whenever nobody owns it.
  always_comb begin
    ram_raddr = '0;
    ram_waddr = '0;
    ram_din   = '0;
    if (own) begin
      for (int i = 0; i < N_CL; i++) begin
        if (gnt_q[i]) begin
          ram_raddr = cl_raddr[i*ADDR_W +: ADDR_W];
          ram_waddr = cl_waddr[i*ADDR_W +: ADDR_W];
          ram_din   = cl_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Reset gates the write strobe combinationally so no write slips through mid-reset.
  assign ram_wen = own_wen & rst;

  // Ownership FSM with registered grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdxW'(N_CL - 1);
      drain_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            gnt_q   <= win;
            last_q  <= win_idx;
            state_q <= StOwn;
          end
        end
        StOwn: begin
          if (!owner_req) begin
            gnt_q   <= '0;
            drain_q <= CntW'(RD_LAT - 1);
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_q == '0) state_q <= StIdle;
          else               drain_q <= drain_q - 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Read-tag pipe: owner one-hot travels RD_LAT stages alongside the RAM read.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= own_ren ? gnt_q : '0;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Sticky protocol-violation flag.
  always_ff @(posedge clk) begin
    if (!rst)       viol_q <= 1'b0;
    else if (stray) viol_q <= 1'b1;
  end

  assign gnt    = gnt_q;
  assign rvalid = tag_q[RD_LAT-1];
  assign rdata  = ram_dout;
  assign viol   = viol_q;
  assign busy   = (state_q != StIdle);

endmodule
